// File: rtl/global_airlight.sv
// Global airlight estimator: dark channel of each 3x3 RGB window, keeping the centre
// pixel of the window with the largest dark channel seen since reset.
module global_airlight #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] a_r,
    input  logic [DW-1:0] b_r,
    input  logic [DW-1:0] c_r,
    input  logic [DW-1:0] d_r,
    input  logic [DW-1:0] e_r,
    input  logic [DW-1:0] f_r,
    input  logic [DW-1:0] g_r,
    input  logic [DW-1:0] h_r,
    input  logic [DW-1:0] i_r,
    input  logic [DW-1:0] a_g,
    input  logic [DW-1:0] b_g,
    input  logic [DW-1:0] c_g,
    input  logic [DW-1:0] d_g,
    input  logic [DW-1:0] e_g,
    input  logic [DW-1:0] f_g,
    input  logic [DW-1:0] g_g,
    input  logic [DW-1:0] h_g,
    input  logic [DW-1:0] i_g,
    input  logic [DW-1:0] a_b,
    input  logic [DW-1:0] b_b,
    input  logic [DW-1:0] c_b,
    input  logic [DW-1:0] d_b,
    input  logic [DW-1:0] e_b,
    input  logic [DW-1:0] f_b,
    input  logic [DW-1:0] g_b,
    input  logic [DW-1:0] h_b,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] arg3_4,
    output logic [DW-1:0] agg3_4,
    output logic [DW-1:0] agb3_4
);

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return (x < y) ? x : y;
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic [DW-1:0] z);
        return min2(min2(x, y), z);
    endfunction

    // Index 0..8 follows the row-major window order a..i; index 4 is the centre pixel.
    logic [8:0][DW-1:0] in_r, in_g, in_b;
    assign in_r = {i_r, h_r, g_r, f_r, e_r, d_r, c_r, b_r, a_r};
    assign in_g = {i_g, h_g, g_g, f_g, e_g, d_g, c_g, b_g, a_g};
    assign in_b = {i_b, h_b, g_b, f_b, e_b, d_b, c_b, b_b, a_b};

    logic [8:0][DW-1:0] s1_r, s1_g, s1_b;
    logic [2:0][DW-1:0] s2_r, s2_g, s2_b;
    logic [DW-1:0]      s2_cr, s2_cg, s2_cb;
    logic [DW-1:0]      s3_dark, s3_cr, s3_cg, s3_cb;
    logic [DW-1:0]      darkmax;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= '0;
            s1_g <= '0;
            s1_b <= '0;
        end else begin
            s1_r <= in_r;
            s1_g <= in_g;
            s1_b <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_r  <= '0;
            s2_g  <= '0;
            s2_b  <= '0;
            s2_cr <= '0;
            s2_cg <= '0;
            s2_cb <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                s2_r[k] <= min3(s1_r[3*k], s1_r[3*k+1], s1_r[3*k+2]);
                s2_g[k] <= min3(s1_g[3*k], s1_g[3*k+1], s1_g[3*k+2]);
                s2_b[k] <= min3(s1_b[3*k], s1_b[3*k+1], s1_b[3*k+2]);
            end
            s2_cr <= s1_r[4];
            s2_cg <= s1_g[4];
            s2_cb <= s1_b[4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_dark <= '0;
            s3_cr   <= '0;
            s3_cg   <= '0;
            s3_cb   <= '0;
        end else begin
            s3_dark <= min3(min3(s2_r[0], s2_r[1], s2_r[2]),
                            min3(s2_g[0], s2_g[1], s2_g[2]),
                            min3(s2_b[0], s2_b[1], s2_b[2]));
            s3_cr   <= s2_cr;
            s3_cg   <= s2_cg;
            s3_cb   <= s2_cb;
        end
    end

    // Strict compare: a tie keeps the earlier window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            darkmax <= '0;
            arg3_4  <= '0;
            agg3_4  <= '0;
            agb3_4  <= '0;
        end else if (s3_dark > darkmax) begin
            darkmax <= s3_dark;
            arg3_4  <= s3_cr;
            agg3_4  <= s3_cg;
            agb3_4  <= s3_cb;
        end
    end

endmodule

// File: tb/tb_global_airlight.sv
// Directed bench for global_airlight: reset behaviour, latency, strict-max update and ties.
module tb_global_airlight;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pr[9];
    logic [7:0] pg[9];
    logic [7:0] pb[9];
    logic [7:0] arg3_4, agg3_4, agb3_4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    global_airlight #(.DW(8)) dut (
        .clk(clk), .reset(reset),
        .a_r(pr[0]), .b_r(pr[1]), .c_r(pr[2]), .d_r(pr[3]), .e_r(pr[4]),
        .f_r(pr[5]), .g_r(pr[6]), .h_r(pr[7]), .i_r(pr[8]),
        .a_g(pg[0]), .b_g(pg[1]), .c_g(pg[2]), .d_g(pg[3]), .e_g(pg[4]),
        .f_g(pg[5]), .g_g(pg[6]), .h_g(pg[7]), .i_g(pg[8]),
        .a_b(pb[0]), .b_b(pb[1]), .c_b(pb[2]), .d_b(pb[3]), .e_b(pb[4]),
        .f_b(pb[5]), .g_b(pb[6]), .h_b(pb[7]), .i_b(pb[8]),
        .arg3_4(arg3_4), .agg3_4(agg3_4), .agb3_4(agb3_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [7:0] fr, input logic [7:0] fg, input logic [7:0] fb,
                           input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
        for (int k = 0; k < 9; k++) begin
            pr[k] = fr;
            pg[k] = fg;
            pb[k] = fb;
        end
        pr[4] = cr;
        pg[4] = cg;
        pb[4] = cb;
    endtask

    // Random pixels capped at 99 so the dark channel never exceeds 99.
    task automatic rand_win();
        for (int k = 0; k < 9; k++) begin
            pr[k] = 8'($urandom_range(99));
            pg[k] = 8'($urandom_range(99));
            pb[k] = 8'($urandom_range(99));
        end
    endtask

    task automatic check(input string tag, input logic [23:0] exp);
        n_checks++;
        assert ({arg3_4, agg3_4, agb3_4} === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, {arg3_4, agg3_4, agb3_4}, exp);
        end
    endtask

    initial begin
        rand_win();
        #1;
        check("reset_at_start", 24'h000000);
        for (int k = 0; k < 3; k++) begin
            tick();
            rand_win();
            check("reset_held", 24'h000000);
        end

        // Test 1: build up state, then assert reset between edges
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_win();
            tick();
        end
        set_win(8'd100, 8'd100, 8'd100, 8'd111, 8'd122, 8'd133);
        tick();
        rand_win();
        tick();
        tick();
        tick();
        check("pre_reset_value", {8'd111, 8'd122, 8'd133});
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_immediate", 24'h000000);
        for (int k = 0; k < 3; k++) begin
            tick();
            rand_win();
            check("async_reset_held", 24'h000000);
        end

        // Test 2: all-zero windows never update
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("zero_windows", 24'h000000);
        end

        // Test 3: dark 50, latency of four edges
        set_win(8'd50, 8'd50, 8'd50, 8'd60, 8'd70, 8'd80);
        tick();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("lat_edge1", 24'h000000);
        tick();
        check("lat_edge2", 24'h000000);
        tick();
        check("lat_edge3", 24'h000000);
        tick();
        check("lat_edge4", {8'd60, 8'd70, 8'd80});

        // Test 4: lower and equal dark values hold, higher updates
        set_win(8'd40, 8'd40, 8'd40, 8'd41, 8'd42, 8'd43);
        tick();
        set_win(8'd50, 8'd50, 8'd50, 8'd51, 8'd52, 8'd53);
        tick();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 4; k++) tick();
        check("lower_and_tie_hold", {8'd60, 8'd70, 8'd80});
        set_win(8'd90, 8'd90, 8'd90, 8'd200, 8'd210, 8'd220);
        tick();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 3; k++) tick();
        check("dark90_update", {8'd200, 8'd210, 8'd220});

        // Test 5: dark 10 via h_b is blocked by darkmax 90, wins after a fresh reset
        set_win(8'd200, 8'd200, 8'd200, 8'd255, 8'd255, 8'd255);
        pb[7] = 8'd10;
        tick();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 3; k++) tick();
        check("dark10_blocked", {8'd200, 8'd210, 8'd220});
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        set_win(8'd200, 8'd200, 8'd200, 8'd255, 8'd255, 8'd255);
        pb[7] = 8'd10;
        tick();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        check("dark10_not_early", 24'h000000);
        tick();
        check("dark10_after_reset", 24'hffffff);

        // Test 6: back-to-back windows dark 30, 60, 45
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        set_win(8'd30, 8'd30, 8'd30, 8'd31, 8'd32, 8'd33);
        tick();
        set_win(8'd60, 8'd60, 8'd60, 8'd61, 8'd62, 8'd63);
        tick();
        set_win(8'd45, 8'd45, 8'd45, 8'd46, 8'd47, 8'd48);
        tick();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        check("b2b_dark30", {8'd31, 8'd32, 8'd33});
        tick();
        check("b2b_dark60", {8'd61, 8'd62, 8'd63});
        tick();
        check("b2b_dark45_hold", {8'd61, 8'd62, 8'd63});
        tick();
        check("b2b_hold", {8'd61, 8'd62, 8'd63});

        // Test 7: minima at scattered positions in different rows and planes
        set_win(8'd255, 8'd255, 8'd255, 8'd250, 8'd251, 8'd252);
        pr[0] = 8'd70;
        pg[5] = 8'd65;
        pb[8] = 8'd62;
        tick();
        set_win(8'd255, 8'd255, 8'd255, 8'd240, 8'd241, 8'd242);
        pr[2] = 8'd63;
        pg[3] = 8'd64;
        pb[6] = 8'd200;
        tick();
        set_win(8'd255, 8'd255, 8'd255, 8'd230, 8'd231, 8'd232);
        pg[1] = 8'd63;
        tick();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        check("scatter_dark62", {8'd250, 8'd251, 8'd252});
        tick();
        check("scatter_dark63", {8'd240, 8'd241, 8'd242});
        tick();
        check("scatter_tie63_hold", {8'd240, 8'd241, 8'd242});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
